// File: rtl/vga_scan_ctrl.sv
// VGA scan-out controller: 640x480@60 timing, sequential VRAM scan addressing,
// and a 2-stage pipeline that aligns sync/DE with registered RGB444 pixels.
module vga_scan_ctrl #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [19:0] VRAM_BASE = 20'h00000
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  input  logic        scan_en,
  output logic [19:0] vram_scan_addr,
  input  logic [15:0] vram_scan_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: raster counters and scan address
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [19:0]   addr;
  logic          en_frame;
  logic          h_wrap, f_wrap;
  logic          vis0, hs0, vs0;

  // Stage 1: controls travelling alongside the outstanding VRAM read
  logic de1, hs1, vs1;

  logic unused_bits;
  assign unused_bits = ^{vram_scan_data[11], vram_scan_data[6:5], vram_scan_data[0]};

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    f_wrap = h_wrap && (v_cnt == V_LAST);
    vis0   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs0    = ~((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs0    = ~((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  end

  always_comb begin
    h_nxt = h_cnt + HW'(1);
    v_nxt = v_cnt;
    if (h_wrap) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end
  end

  assign vram_scan_addr = addr;

  // Address advances only past visible pixels, so line ends need no reload
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr     <= VRAM_BASE;
      en_frame <= 1'b0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (f_wrap) begin
        addr     <= VRAM_BASE;
        en_frame <= scan_en;
      end else if (vis0) begin
        addr <= addr + 20'd1;
      end
    end
  end

  // frame_start/vblank are derived from the next counter values so they
  // line up with the stage-0 position they describe.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= f_wrap;
      vblank      <= (v_nxt >= V_VIS_END);
    end
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      de1 <= vis0;
      hs1 <= hs0;
      vs1 <= vs0;
    end
  end

  // Stage 2: vram_scan_data belongs to the stage-1 pixel here
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      vga_de <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_de <= de1;
      vga_hs <= hs1;
      vga_vs <= vs1;
      if (de1 && en_frame) begin
        vga_r <= vram_scan_data[15:12];
        vga_g <= vram_scan_data[10:7];
        vga_b <= vram_scan_data[4:1];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a shrunken 16x9 raster (8x4 visible)
// with a VRAM base near the top of the 20-bit space to exercise address wrap.
module tb_vga_scan_ctrl;

  localparam logic [19:0] BASE = 20'hFFFF0;

  logic        clk_25mhz = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [19:0] vram_scan_addr;
  logic [15:0] vram_scan_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start, vblank;

  logic        const_mode;
  int          vectors = 0;
  int          miscompares = 0;
  int          k = 0;

  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .VRAM_BASE(BASE)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst(rst),
    .scan_en(scan_en),
    .vram_scan_addr(vram_scan_addr),
    .vram_scan_data(vram_scan_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .frame_start(frame_start),
    .vblank(vblank)
  );

  // Clock and SRAM scan-port model (one-cycle read latency)
  always #5 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz)
    vram_scan_data <= const_mode ? 16'hF81F : vram_scan_addr[15:0];

  task automatic step();
    @(posedge clk_25mhz);
    #1;
    k++;
  endtask

  task automatic goto(input int t);
    while (k < t) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [11:0] exp);
    check(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
  endtask

  initial begin
    rst        = 1'b1;
    scan_en    = 1'b1;
    const_mode = 1'b0;
    repeat (3) step();

    check("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    check("rst_hs", vga_hs, 1'b1);
    check("rst_vs", vga_vs, 1'b1);
    check("rst_de", vga_de, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_vblank", vblank, 1'b0);
    check("rst_addr", vram_scan_addr, BASE);

    rst = 1'b0;
    k = 0;

    // Frame 1: en_frame still 0, so visible pixels are black
    goto(2);  check("f1_de", vga_de, 1'b1); check_rgb("f1_black", 12'h000);
    goto(5);  check("addr_px5", vram_scan_addr, 20'hFFFF5);
    goto(11); check("hs_before", vga_hs, 1'b1);
    goto(12); check("hs_first_low", vga_hs, 1'b0);
    goto(14); check("hs_last_low", vga_hs, 1'b0);
    goto(15); check("hs_after", vga_hs, 1'b1); check("addr_hold_hblank", vram_scan_addr, 20'hFFFF8);
    goto(16); check("addr_line1_px0", vram_scan_addr, 20'hFFFF8);
    goto(55); check("addr_last_vis", vram_scan_addr, 20'h0000F);
    goto(56); check("addr_after_last", vram_scan_addr, 20'h00010);
    goto(63); check("vblank_pre", vblank, 1'b0);
    goto(64); check("vblank_rise", vblank, 1'b1);
    goto(81); check("vs_before", vga_vs, 1'b1);
    goto(82); check("vs_first_low", vga_vs, 1'b0);
    goto(100); check("addr_hold_vblank", vram_scan_addr, 20'h00010);
    goto(113); check("vs_last_low", vga_vs, 1'b0);
    goto(114); check("vs_after", vga_vs, 1'b1);
    goto(143); check("fs_pre", frame_start, 1'b0);

    // Frame 2: addr-valued data
    goto(144);
    check("fs_f2", frame_start, 1'b1);
    check("vblank_fall", vblank, 1'b0);
    check("addr_reload", vram_scan_addr, BASE);
    goto(145); check("fs_one_cycle", frame_start, 1'b0);
    goto(146); check_rgb("f2_px00", 12'hFF8);
    goto(167); check_rgb("f2_px51", 12'hFFE);
    goto(170); check("f2_blank_de", vga_de, 1'b0); check_rgb("f2_blank_rgb", 12'h000);
    goto(197); check_rgb("f2_px33", 12'h005);
    goto(200); const_mode = 1'b1;

    // Frame 3: constant magenta, scan_en dropped mid-frame
    goto(308); check("f3_de", vga_de, 1'b1); check_rgb("f3_px21", 12'hF0F);
    goto(314); check_rgb("f3_blank_rgb", 12'h000);
    goto(320); scan_en = 1'b0;
    goto(326); check_rgb("f3_after_drop", 12'hF0F);

    // Frame 4: black, timing unchanged
    goto(432); check("fs_f4", frame_start, 1'b1);
    goto(444); check("f4_hs_low", vga_hs, 1'b0);
    goto(470); check("f4_de", vga_de, 1'b1); check_rgb("f4_black", 12'h000);
    goto(475); scan_en = 1'b1;
    goto(484);
    check("pre_rst_de", vga_de, 1'b1);

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #1;
    check("arst_de", vga_de, 1'b0);
    check("arst_addr", vram_scan_addr, BASE);
    check("arst_hs", vga_hs, 1'b1);
    repeat (3) step();
    rst = 1'b0;
    k = 0;

    goto(2);  check("post_rst_de", vga_de, 1'b1); check_rgb("post_rst_black", 12'h000);
    goto(3);  check("post_rst_addr", vram_scan_addr, 20'hFFFF3);
    goto(64); check("post_rst_vblank", vblank, 1'b1);
    goto(144); check("post_rst_fs", frame_start, 1'b1);
    goto(146); check_rgb("post_rst_f2", 12'hF0F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
